// File: rtl/fan_pkg.sv
// Shared types and constants for the fan PWM generator.
package fan_pkg;

  localparam int unsigned DUTY_W = 7;

  localparam logic [1:0] SPEED_OFF  = 2'd0;
  localparam logic [1:0] SPEED_LOW  = 2'd1;
  localparam logic [1:0] SPEED_MED  = 2'd2;
  localparam logic [1:0] SPEED_HIGH = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } fan_state_t;

endpackage

// File: rtl/fan_pwm_generator_if.sv
// Speed request valid/ready channel into the fan PWM generator.
interface fan_pwm_generator_if;

  logic [1:0] speed_sel;
  logic       speed_valid;
  logic       speed_ready;

  modport master (output speed_sel, output speed_valid, input speed_ready);
  modport slave  (input speed_sel, input speed_valid, output speed_ready);

endinterface

// File: rtl/tick_edge_detect.sv
// Rising-edge detector: a held-high tick level yields a single tick pulse.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_p
);

  logic tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= tick_in;
  end

  assign tick_p = tick_in & ~tick_q;

endmodule

// File: rtl/fan_pwm_generator.sv
// Fan drive PWM with a speed request handshake and per-period soft ramping of the duty.
module fan_pwm_generator
  import fan_pkg::*;
#(
  parameter int unsigned PERIOD    = 100,
  parameter int unsigned RAMP_STEP = 5,
  parameter int unsigned DUTY_LOW  = 30,
  parameter int unsigned DUTY_MED  = 60,
  parameter int unsigned DUTY_HIGH = 100
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                tick_in,
  fan_pwm_generator_if.slave  speed,
  output logic                pwm_out,
  output logic [DUTY_W-1:0]   duty_cur,
  output logic                at_speed
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] ONE      = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(RAMP_STEP);
  localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W + 1)'(RAMP_STEP);

  fan_state_t        state, state_next;
  logic [DUTY_W-1:0] cnt, cnt_next;
  logic [DUTY_W-1:0] target, target_next;
  logic [DUTY_W-1:0] duty_next, sel_duty, up_val, down_val;
  logic [DUTY_W:0]   up_sum;
  logic              tick_p, boundary, accept;
  logic              ready_q, ready_next, pwm_next, at_speed_next;

  tick_edge_detect u_tick (
    .clk     (clk_in),
    .rst     (rst),
    .tick_in (tick_in),
    .tick_p  (tick_p)
  );

  assign speed.speed_ready = ready_q;

  // Speed level to duty ticks
  always_comb begin
    sel_duty = '0;
    case (speed.speed_sel)
      SPEED_LOW:  sel_duty = DUTY_W'(DUTY_LOW);
      SPEED_MED:  sel_duty = DUTY_W'(DUTY_MED);
      SPEED_HIGH: sel_duty = DUTY_W'(DUTY_HIGH);
      default:    sel_duty = '0;
    endcase
  end

  // Clamped ramp steps; the down step compares before subtracting so it cannot underflow
  assign up_sum   = {1'b0, duty_cur} + STEP_X;
  assign up_val   = (up_sum >= {1'b0, target}) ? target : up_sum[DUTY_W-1:0];
  assign down_val = ({1'b0, duty_cur} >= ({1'b0, target} + STEP_X)) ? (duty_cur - STEP) : target;

  assign accept   = speed.speed_valid & ready_q;
  assign boundary = tick_p & (cnt == CNT_LAST);

  always_comb begin
    state_next  = state;
    duty_next   = duty_cur;
    target_next = target;
    cnt_next    = cnt;
    case (state)
      IDLE: begin
        duty_next = '0;
        if (accept) begin
          target_next = sel_duty;
          if (sel_duty != '0) state_next = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (boundary) begin
          duty_next = up_val;
          if (up_val == target) state_next = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          target_next = sel_duty;
          if (sel_duty > duty_cur)      state_next = RAMP_UP;
          else if (sel_duty < duty_cur) state_next = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (boundary) begin
          duty_next = down_val;
          if (down_val == target) state_next = (target == '0) ? IDLE : RUN;
        end
      end
      default: state_next = IDLE;
    endcase

    if (tick_p) cnt_next = (cnt == CNT_LAST) ? '0 : (cnt + ONE);

    pwm_next      = tick_p ? (cnt_next < duty_next) : pwm_out;
    ready_next    = (state_next == IDLE) || (state_next == RUN);
    at_speed_next = ready_next && (duty_next == target_next);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      target   <= '0;
      duty_cur <= '0;
      pwm_out  <= 1'b0;
      ready_q  <= 1'b1;
      at_speed <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      target   <= target_next;
      duty_cur <= duty_next;
      pwm_out  <= pwm_next;
      ready_q  <= ready_next;
      at_speed <= at_speed_next;
    end
  end

endmodule

// File: tb/tb_fan_pwm_generator.sv
// Directed bench for fan_pwm_generator with default parameters.
module tb_fan_pwm_generator;
  import fan_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       pwm_out;
  logic [6:0] duty_cur;
  logic       at_speed;
  int         checks   = 0;
  int         failures = 0;

  fan_pwm_generator_if spd ();

  fan_pwm_generator dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .tick_in  (tick_in),
    .speed    (spd),
    .pwm_out  (pwm_out),
    .duty_cur (duty_cur),
    .at_speed (at_speed)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(negedge clk_in) tick_in = 1'b1;
    @(negedge clk_in) tick_in = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic request(input logic [1:0] sel);
    @(negedge clk_in);
    spd.speed_sel   = sel;
    spd.speed_valid = 1'b1;
    @(negedge clk_in);
    spd.speed_valid = 1'b0;
  endtask

  task automatic wait_at_speed(input string name);
    int n = 0;
    while (!at_speed && n < 2500) begin
      tick();
      n++;
    end
    checks++;
    if (at_speed !== 1'b1) begin
      failures++;
      $display("FAIL %s wait_at_speed: at_speed=%b after %0d ticks, required 1", name, at_speed, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_in = 1'b0; spd.speed_sel = SPEED_OFF; spd.speed_valid = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    checks++; if (pwm_out !== 1'b0)     begin failures++; $display("FAIL reset pwm_out: got %b want 0", pwm_out); end
    checks++; if (duty_cur !== 7'd0)    begin failures++; $display("FAIL reset duty_cur: got %0d want 0", duty_cur); end
    checks++; if (spd.speed_ready !== 1'b1) begin failures++; $display("FAIL reset speed_ready: got %b want 1", spd.speed_ready); end
    checks++; if (at_speed !== 1'b1)    begin failures++; $display("FAIL reset at_speed: got %b want 1", at_speed); end
  endtask

  task automatic test_soft_start();
    int highs = 0;
    request(SPEED_HIGH);
    checks++; if (spd.speed_ready !== 1'b0) begin failures++; $display("FAIL start speed_ready: got %b want 0", spd.speed_ready); end
    checks++; if (at_speed !== 1'b0) begin failures++; $display("FAIL start at_speed: got %b want 0", at_speed); end
    for (int p = 1; p <= 20; p++) begin
      ticks(100);
      checks++;
      if (duty_cur !== 7'(5 * p)) begin
        failures++; $display("FAIL start duty period %0d: got %0d want %0d", p, duty_cur, 5 * p);
      end
    end
    checks++; if (at_speed !== 1'b1) begin failures++; $display("FAIL start final at_speed: got %b want 1", at_speed); end
    checks++; if (spd.speed_ready !== 1'b1) begin failures++; $display("FAIL start final speed_ready: got %b want 1", spd.speed_ready); end
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
    end
    checks++; if (highs != 100) begin failures++; $display("FAIL start full duty highs: got %0d want 100", highs); end
  endtask

  task automatic test_steady_low();
    int highs = 0;
    request(SPEED_LOW);
    wait_at_speed("low");
    checks++; if (duty_cur !== 7'd30) begin failures++; $display("FAIL low duty: got %0d want 30", duty_cur); end
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
    end
    checks++; if (highs != 30) begin failures++; $display("FAIL low highs per period: got %0d want 30", highs); end
  endtask

  task automatic test_soft_stop();
    request(SPEED_MED);
    wait_at_speed("to_med");
    checks++; if (duty_cur !== 7'd60) begin failures++; $display("FAIL stop start duty: got %0d want 60", duty_cur); end
    request(SPEED_OFF);
    for (int k = 1; k <= 12; k++) begin
      checks++;
      if (spd.speed_ready !== 1'b0) begin
        failures++; $display("FAIL stop speed_ready before period %0d: got %b want 0", k, spd.speed_ready);
      end
      ticks(100);
      checks++;
      if (duty_cur !== 7'(60 - 5 * k)) begin
        failures++; $display("FAIL stop duty period %0d: got %0d want %0d", k, duty_cur, 60 - 5 * k);
      end
    end
    checks++; if (spd.speed_ready !== 1'b1) begin failures++; $display("FAIL stop final speed_ready: got %b want 1", spd.speed_ready); end
    checks++; if (at_speed !== 1'b1) begin failures++; $display("FAIL stop final at_speed: got %b want 1", at_speed); end
    ticks(7);
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL stop pwm_out: got %b want 0", pwm_out); end
    ticks(93);
  endtask

  task automatic test_held_valid();
    @(negedge clk_in);
    spd.speed_sel = SPEED_HIGH; spd.speed_valid = 1'b1;
    @(negedge clk_in);
    spd.speed_sel = SPEED_MED;
    for (int p = 1; p <= 20; p++) begin
      ticks(100);
      checks++;
      if (duty_cur !== 7'(5 * p)) begin
        failures++; $display("FAIL held duty up period %0d: got %0d want %0d", p, duty_cur, 5 * p);
      end
    end
    checks++; if (spd.speed_ready !== 1'b1) begin failures++; $display("FAIL held ready at RUN: got %b want 1", spd.speed_ready); end
    @(negedge clk_in);
    spd.speed_valid = 1'b0;
    checks++; if (spd.speed_ready !== 1'b0) begin failures++; $display("FAIL held accept: speed_ready got %b want 0", spd.speed_ready); end
    for (int p = 1; p <= 8; p++) begin
      ticks(100);
      checks++;
      if (duty_cur !== 7'(100 - 5 * p)) begin
        failures++; $display("FAIL held duty down period %0d: got %0d want %0d", p, duty_cur, 100 - 5 * p);
      end
    end
    checks++; if (at_speed !== 1'b1) begin failures++; $display("FAIL held final at_speed: got %b want 1", at_speed); end
  endtask

  task automatic test_mid_ramp_reset();
    @(negedge clk_in) rst = 1'b1;
    @(negedge clk_in) rst = 1'b0;
    request(SPEED_HIGH);
    ticks(500);
    checks++; if (duty_cur !== 7'd25) begin failures++; $display("FAIL midrst pre duty: got %0d want 25", duty_cur); end
    checks++; if (pwm_out !== 1'b1)   begin failures++; $display("FAIL midrst pre pwm_out: got %b want 1", pwm_out); end
    @(negedge clk_in);
    rst = 1'b1; tick_in = 1'b1;
    #1;
    checks++; if (duty_cur !== 7'd0) begin failures++; $display("FAIL midrst async duty: got %0d want 0", duty_cur); end
    checks++; if (pwm_out !== 1'b0)  begin failures++; $display("FAIL midrst async pwm_out: got %b want 0", pwm_out); end
    checks++; if (spd.speed_ready !== 1'b1) begin failures++; $display("FAIL midrst async speed_ready: got %b want 1", spd.speed_ready); end
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);
    tick_in = 1'b0;
    @(negedge clk_in);
    request(SPEED_LOW);
    ticks(98);
    checks++; if (duty_cur !== 7'd0) begin failures++; $display("FAIL midrst single tick before boundary: duty got %0d want 0", duty_cur); end
    tick();
    checks++; if (duty_cur !== 7'd5) begin failures++; $display("FAIL midrst single tick at boundary: duty got %0d want 5", duty_cur); end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_steady_low();
    test_soft_stop();
    test_held_valid();
    test_mid_ramp_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
